// File: rtl/icache_mshr_pkg.sv
// Shared MSHR types: per-entry state, entry record, address/tag widths and block helpers.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 4
`endif

package icache_mshr_pkg;

  localparam int ADDR_W    = 32;
  localparam int MEM_TAG_W = $clog2(`NUM_MEM_TAGS + 1);

  typedef logic [ADDR_W-1:0]    ADDR;
  typedef logic [MEM_TAG_W-1:0] MEM_TAG;

  typedef enum logic [1:0] {
    MSHR_FREE    = 2'd0,
    MSHR_PENDING = 2'd1,
    MSHR_ORPHAN  = 2'd2
  } MSHR_STATE;

  typedef struct packed {
    MSHR_STATE state;
    ADDR       addr;
    MEM_TAG    mem_tag;
  } MSHR_ENTRY;

  function automatic ADDR block_align(input ADDR a, input int off);
    return a & ~((ADDR'(1) << off) - ADDR'(1));
  endfunction

  function automatic logic block_match(input ADDR a, input ADDR b, input int off);
    return (a >> off) == (b >> off);
  endfunction

endpackage

// File: rtl/icache_mshr_if.sv
// Handshake bundle between the icache miss path and the MSHR table.
interface icache_mshr_if
  import icache_mshr_pkg::*;
#(
  parameter int NUM_ENTRIES = `NUM_MEM_TAGS
);
  logic                             alloc_valid;
  ADDR                              alloc_addr;
  MEM_TAG                           alloc_mem_tag;
  logic                             alloc_ready;
  ADDR                              snoop_addr;
  logic                             snoop_hit;
  MEM_TAG                           return_tag;
  logic                             flush;
  logic                             fill_valid;
  ADDR                              fill_addr;
  logic [$clog2(NUM_ENTRIES+1)-1:0] pending_count;

  modport master (
    output alloc_valid, alloc_addr, alloc_mem_tag, snoop_addr, return_tag, flush,
    input  alloc_ready, snoop_hit, fill_valid, fill_addr, pending_count
  );

  modport slave (
    input  alloc_valid, alloc_addr, alloc_mem_tag, snoop_addr, return_tag, flush,
    output alloc_ready, snoop_hit, fill_valid, fill_addr, pending_count
  );
endinterface

// File: rtl/icache_mshr_entry.sv
// One MSHR slot: FREE/PENDING/ORPHAN state machine plus tag and block-address compare.
module mshr_entry
  import icache_mshr_pkg::*;
#(
  parameter int BLOCK_OFFSET_BITS = 3
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      alloc,
  input  ADDR       alloc_addr,
  input  MEM_TAG    alloc_mem_tag,
  input  MEM_TAG    return_tag,
  input  logic      flush,
  input  ADDR       snoop_addr,
  output MSHR_ENTRY entry,
  output logic      busy_next,
  output logic      ret_hit,
  output logic      fill,
  output logic      snoop_hit
);
  MSHR_STATE state, state_next;
  ADDR       addr;
  MEM_TAG    mem_tag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= MSHR_FREE;
      addr    <= '0;
      mem_tag <= '0;
    end else begin
      state <= state_next;
      if (alloc) begin
        addr    <= block_align(alloc_addr, BLOCK_OFFSET_BITS);
        mem_tag <= alloc_mem_tag;
      end
    end
  end

  assign ret_hit   = (state != MSHR_FREE) && (return_tag != '0) && (return_tag == mem_tag);
  // A flush landing with the return turns the fill into an orphan drop.
  assign fill      = ret_hit && (state == MSHR_PENDING) && !flush;
  assign snoop_hit = (state == MSHR_PENDING) && block_match(snoop_addr, addr, BLOCK_OFFSET_BITS);

  always_comb begin
    state_next = state;
    unique case (state)
      MSHR_FREE:    if (alloc) state_next = MSHR_PENDING;
      MSHR_PENDING: begin
        if (ret_hit)    state_next = MSHR_FREE;
        else if (flush) state_next = MSHR_ORPHAN;
      end
      MSHR_ORPHAN:  if (ret_hit) state_next = MSHR_FREE;
      default:      state_next = MSHR_FREE;
    endcase
  end

  assign busy_next = (state_next != MSHR_FREE);
  assign entry     = '{state: state, addr: addr, mem_tag: mem_tag};
endmodule

// File: rtl/psel_gen.sv
// Priority selector: grants up to REQS requesters, lowest index first; purely combinational.
module psel_gen #(
  parameter int WIDTH = 4,
  parameter int REQS  = 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             empty
);
  logic [WIDTH-1:0] remaining;
  logic             taken;

  always_comb begin
    gnt       = '0;
    remaining = req;
    taken     = 1'b0;
    for (int r = 0; r < REQS; r++) begin
      taken = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (remaining[i] && !taken) begin
          gnt[i]       = 1'b1;
          remaining[i] = 1'b0;
          taken        = 1'b1;
        end
      end
    end
  end

  assign empty = ~|req;
endmodule

// File: rtl/icache_mshr.sv
// Icache miss-status table: tracks outstanding memory tags, fills on return, drops flushed misses.
// ICACHE_MSHR_SNOOP_BYPASS_EN: snoop also matches the alloc accepted in the same cycle.
module icache_mshr
  import icache_mshr_pkg::*;
#(
  parameter int NUM_ENTRIES       = `NUM_MEM_TAGS,
  parameter int BLOCK_OFFSET_BITS = 3
) (
  input logic          clock,
  input logic          reset,
  icache_mshr_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  MSHR_ENTRY              entries [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] free_vec, gnt, busy_next, ret_hit, fill, snoop_vec;
  logic                   none_free, alloc_go, tag_clash;
  ADDR                    fill_addr_next, fill_addr_q;
  logic                   fill_valid_q;
  logic [CNT_W-1:0]       count_next, count_q;

  psel_gen #(.WIDTH(NUM_ENTRIES), .REQS(1)) u_psel (
    .req   (free_vec),
    .gnt   (gnt),
    .empty (none_free)
  );

  // Readiness comes from registered state only, so a slot freed this cycle is not reusable yet.
  assign bus.alloc_ready = !none_free;
  assign alloc_go        = bus.alloc_valid && !none_free && !bus.flush;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : gen_entry
    mshr_entry #(.BLOCK_OFFSET_BITS(BLOCK_OFFSET_BITS)) u_entry (
      .clock         (clock),
      .reset         (reset),
      .alloc         (alloc_go && gnt[i]),
      .alloc_addr    (bus.alloc_addr),
      .alloc_mem_tag (bus.alloc_mem_tag),
      .return_tag    (bus.return_tag),
      .flush         (bus.flush),
      .snoop_addr    (bus.snoop_addr),
      .entry         (entries[i]),
      .busy_next     (busy_next[i]),
      .ret_hit       (ret_hit[i]),
      .fill          (fill[i]),
      .snoop_hit     (snoop_vec[i])
    );
    assign free_vec[i] = (entries[i].state == MSHR_FREE);
  end

  always_comb begin
    fill_addr_next = '0;
    count_next     = '0;
    tag_clash      = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (fill[i])      fill_addr_next = fill_addr_next | entries[i].addr;
      if (busy_next[i]) count_next     = count_next + CNT_W'(1);
      if ((entries[i].state != MSHR_FREE) && !ret_hit[i] &&
          (entries[i].mem_tag == bus.alloc_mem_tag))
        tag_clash = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      count_q      <= '0;
    end else begin
      fill_valid_q <= |fill;
      if (|fill) fill_addr_q <= fill_addr_next;
      count_q      <= count_next;
    end
  end

  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_addr     = fill_addr_q;
  assign bus.pending_count = count_q;

`ifdef ICACHE_MSHR_SNOOP_BYPASS_EN
  assign bus.snoop_hit = (|snoop_vec) ||
                         (alloc_go && block_match(bus.snoop_addr, bus.alloc_addr, BLOCK_OFFSET_BITS));
`else
  assign bus.snoop_hit = |snoop_vec;
`endif

  // Memory must never hand out a tag that is still reserved by a live or orphaned miss.
  a_no_tag_reuse: assert property (@(posedge clock) disable iff (reset) !(alloc_go && tag_clash));
endmodule

// File: tb/tb_icache_mshr.sv
// Directed bench for icache_mshr: slot-level reference model checked every cycle plus literal pins.
module tb_icache_mshr;
  import icache_mshr_pkg::*;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  icache_mshr_if #(.NUM_ENTRIES(N)) mif ();
  icache_mshr #(.NUM_ENTRIES(N), .BLOCK_OFFSET_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clock = ~clock;

  // Reference model: slot_tag==0 means the slot is free.
  int          slot_tag  [N];
  logic [31:0] slot_addr [N];
  bit          slot_orph [N];
  bit          exp_fv = 1'b0;
  logic [31:0] exp_fa = '0;
  int          exp_cnt = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit m_ready();
    for (int i = 0; i < N; i++) if (slot_tag[i] == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_snoop();
    bit hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (slot_tag[i] != 0 && !slot_orph[i] && (slot_addr[i] >> 3) == (mif.snoop_addr >> 3)) hit = 1'b1;
`ifdef ICACHE_MSHR_SNOOP_BYPASS_EN
    if (mif.alloc_valid && m_ready() && !mif.flush && (mif.alloc_addr >> 3) == (mif.snoop_addr >> 3))
      hit = 1'b1;
`endif
    return hit;
  endfunction

  always @(posedge clock) begin : model
    int asel;
    bit fv;
    int cnt;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        slot_tag[i] = 0; slot_addr[i] = '0; slot_orph[i] = 1'b0;
      end
      exp_fv = 1'b0; exp_fa = '0; exp_cnt = 0;
    end else begin
      asel = -1;
      fv   = 1'b0;
      for (int i = 0; i < N; i++) if (slot_tag[i] == 0 && asel < 0) asel = i;
      if (mif.return_tag != '0)
        for (int i = 0; i < N; i++)
          if (slot_tag[i] == int'(mif.return_tag)) begin
            if (!slot_orph[i] && !mif.flush) begin
              fv = 1'b1; exp_fa = slot_addr[i];
            end
            slot_tag[i] = 0; slot_orph[i] = 1'b0;
          end
      if (mif.flush)
        for (int i = 0; i < N; i++) if (slot_tag[i] != 0) slot_orph[i] = 1'b1;
      if (mif.alloc_valid && asel >= 0 && !mif.flush) begin
        slot_tag[asel]  = int'(mif.alloc_mem_tag);
        slot_addr[asel] = mif.alloc_addr & ~32'h7;
        slot_orph[asel] = 1'b0;
      end
      cnt = 0;
      for (int i = 0; i < N; i++) if (slot_tag[i] != 0) cnt++;
      exp_fv  = fv;
      exp_cnt = cnt;
    end
  end

  always @(negedge clock) begin
    #2;
    if (chk_en) begin
      cmp("alloc_ready", 32'(mif.alloc_ready), 32'(m_ready()));
      cmp("snoop_hit", 32'(mif.snoop_hit), 32'(m_snoop()));
      cmp("fill_valid", 32'(mif.fill_valid), 32'(exp_fv));
      if (exp_fv) cmp("fill_addr", mif.fill_addr, exp_fa);
      cmp("pending_count", 32'(mif.pending_count), 32'(exp_cnt));
    end
  end

  task automatic drive(input bit av, input logic [31:0] aa, input int at,
                       input logic [31:0] sa, input int rt, input bit fl);
    @(negedge clock);
    mif.alloc_valid   = av;
    mif.alloc_addr    = aa;
    mif.alloc_mem_tag = MEM_TAG'(at);
    mif.snoop_addr    = sa;
    mif.return_tag    = MEM_TAG'(rt);
    mif.flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 0, 32'h0, 0, 1'b0);
  endtask

  task automatic alloc(input logic [31:0] aa, input int at);
    drive(1'b1, aa, at, 32'h0, 0, 1'b0);
  endtask

  task automatic ret(input int rt);
    drive(1'b0, 32'h0, 0, 32'h0, rt, 1'b0);
  endtask

  initial begin
    mif.alloc_valid = 1'b0; mif.alloc_addr = '0; mif.alloc_mem_tag = '0;
    mif.snoop_addr = '0; mif.return_tag = '0; mif.flush = 1'b0;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    #3;
    cmp("lit_reset_count", 32'(mif.pending_count), 32'd0);
    cmp("lit_reset_ready", 32'(mif.alloc_ready), 32'd1);
    cmp("lit_reset_fill_valid", 32'(mif.fill_valid), 32'd0);
    cmp("lit_reset_fill_addr", mif.fill_addr, 32'h0);
    cmp("lit_reset_snoop", 32'(mif.snoop_hit), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single miss and fill.
    alloc(32'h1000, 1);
    ret(1);
    #3 cmp("lit_single_count_before", 32'(mif.pending_count), 32'd1);
    idle();
    #3;
    cmp("lit_single_fill_valid", 32'(mif.fill_valid), 32'd1);
    cmp("lit_single_fill_addr", mif.fill_addr, 32'h1000);
    cmp("lit_single_count_after", 32'(mif.pending_count), 32'd0);

    // Full table, ignored alloc, return frees slot 2, realloc lands there.
    for (int t = 1; t <= 4; t++) alloc(32'(t) << 12, t);
    alloc(32'h5000, 5);
    #3 cmp("lit_full_ready", 32'(mif.alloc_ready), 32'd0);
    ret(3);
    #3 cmp("lit_full_count", 32'(mif.pending_count), 32'd4);
    cmp("lit_ready_same_cycle_return", 32'(mif.alloc_ready), 32'd0);
    alloc(32'h5000, 3);
    #3 cmp("lit_ready_after_return", 32'(mif.alloc_ready), 32'd1);
    cmp("lit_fill_tag3", mif.fill_addr, 32'h3000);
    idle();
    #3;
    cmp("lit_realloc_entry2_addr", dut.gen_entry[2].u_entry.addr, 32'h5000);
    cmp("lit_realloc_entry2_tag", 32'(dut.gen_entry[2].u_entry.mem_tag), 32'd3);
    for (int t = 1; t <= 4; t++) ret(t);
    idle();

    // Snoop, flush to orphan, orphan return gives no fill.
    alloc(32'h2000, 2);
    drive(1'b0, 32'h0, 0, 32'h2004, 0, 1'b0);
    #3 cmp("lit_snoop_hit", 32'(mif.snoop_hit), 32'd1);
    drive(1'b0, 32'h0, 0, 32'h2004, 0, 1'b1);
    drive(1'b0, 32'h0, 0, 32'h2004, 0, 1'b0);
    #3;
    cmp("lit_snoop_after_flush", 32'(mif.snoop_hit), 32'd0);
    cmp("lit_orphan_count", 32'(mif.pending_count), 32'd1);
    ret(2);
    idle();
    #3;
    cmp("lit_orphan_no_fill", 32'(mif.fill_valid), 32'd0);
    cmp("lit_orphan_count_after", 32'(mif.pending_count), 32'd0);

    // Out-of-order returns; unaligned alloc address comes back block-aligned.
    alloc(32'h1107, 1);
    alloc(32'h2200, 2);
    alloc(32'h3300, 3);
    ret(3);
    ret(1);
    #3 cmp("lit_ooo_first", mif.fill_addr, 32'h3300);
    ret(2);
    #3 cmp("lit_ooo_second", mif.fill_addr, 32'h1100);
    idle();
    #3 cmp("lit_ooo_third", mif.fill_addr, 32'h2200);

    // Flush with same-cycle alloc and return.
    alloc(32'h1000, 1);
    alloc(32'h2000, 2);
    drive(1'b1, 32'h3000, 3, 32'h0, 1, 1'b1);
    idle();
    #3;
    cmp("lit_flush_ret_no_fill", 32'(mif.fill_valid), 32'd0);
    cmp("lit_flush_alloc_dropped", 32'(mif.pending_count), 32'd1);
    ret(2);
    idle();

    // Same-cycle alloc and snoop on the alloc address.
    drive(1'b1, 32'h3000, 3, 32'h3000, 0, 1'b0);
`ifdef ICACHE_MSHR_SNOOP_BYPASS_EN
    #3 cmp("lit_bypass_snoop", 32'(mif.snoop_hit), 32'd1);
`else
    #3 cmp("lit_no_bypass_snoop", 32'(mif.snoop_hit), 32'd0);
`endif
    ret(3);
    idle();

    // Same-cycle alloc and return: freed slot not reusable, other free slot is.
    for (int t = 1; t <= 4; t++) alloc(32'h8000 + (32'(t) << 4), t);
    drive(1'b1, 32'h6000, 5, 32'h0, 2, 1'b0);
    idle();
    #3 cmp("lit_freed_not_reused", 32'(mif.pending_count), 32'd3);
    drive(1'b1, 32'h7000, 2, 32'h0, 1, 1'b0);
    idle();
    #3 cmp("lit_alloc_and_return", 32'(mif.pending_count), 32'd3);
    ret(2);
    idle();
    #3 cmp("lit_realloc_fill", mif.fill_addr, 32'h7000);
    ret(3);
    ret(4);
    ret(6);
    idle();

    // Reset mid-operation discards entries; stale returns are ignored.
    alloc(32'h1000, 1);
    alloc(32'h2000, 2);
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    #3 cmp("lit_midreset_count", 32'(mif.pending_count), 32'd0);
    ret(1);
    idle();
    #3 cmp("lit_midreset_no_fill", 32'(mif.fill_valid), 32'd0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
